// File: rtl/regwrite_arbiter_if.sv
// Register-file write request/grant bundle shared by the two requesters
// and the arbitrated write port.
interface regwrite_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_src;
   logic              busy;

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, wr_en, wr_addr, wr_data, wr_src, busy
   );

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data, wr_src, busy
   );
endinterface

// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter: one-entry buffer per requester,
// round-robin on conflicts, oldest-first when both target the same register.
module regwrite_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               reset,
   regwrite_arbiter_if.slave bus
);
   logic              a_full_q, a_full_d, b_full_q, b_full_d;
   logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
   logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
   logic              rr_ptr_q, rr_ptr_d;     // 0 = A next, 1 = B next
   logic              b_older_q, b_older_d;   // meaningful only while both full
   logic              gnt_a, gnt_b, a_rdy, b_rdy, a_load, b_load;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset) begin
         if (a_full_q && b_full_q) begin
            gnt_b = (a_addr_q == b_addr_q) ? b_older_q : rr_ptr_q;
            gnt_a = !gnt_b;
         end else begin
            gnt_a = a_full_q;
            gnt_b = b_full_q;
         end
      end
   end

   assign a_rdy  = !reset && (!a_full_q || gnt_a);
   assign b_rdy  = !reset && (!b_full_q || gnt_b);
   assign a_load = bus.a_valid && a_rdy && (bus.a_addr != '0);
   assign b_load = bus.b_valid && b_rdy && (bus.b_addr != '0);

   always_comb begin
      a_full_d  = a_full_q && !gnt_a;
      a_addr_d  = a_addr_q;
      a_data_d  = a_data_q;
      b_full_d  = b_full_q && !gnt_b;
      b_addr_d  = b_addr_q;
      b_data_d  = b_data_q;
      rr_ptr_d  = rr_ptr_q;
      b_older_d = b_older_q;
      if (a_load) begin
         a_full_d = 1'b1;
         a_addr_d = bus.a_addr;
         a_data_d = bus.a_data;
      end
      if (b_load) begin
         b_full_d = 1'b1;
         b_addr_d = bus.b_addr;
         b_data_d = bus.b_data;
      end
      if (a_full_q && b_full_q)
         rr_ptr_d = gnt_a;
      // Same-edge acceptance leaves A older; a lone new entry is younger than a survivor.
      if (b_load)
         b_older_d = 1'b0;
      else if (a_load)
         b_older_d = b_full_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_full_q  <= 1'b0;
         a_addr_q  <= '0;
         a_data_q  <= '0;
         b_full_q  <= 1'b0;
         b_addr_q  <= '0;
         b_data_q  <= '0;
         rr_ptr_q  <= 1'b0;
         b_older_q <= 1'b0;
      end else begin
         a_full_q  <= a_full_d;
         a_addr_q  <= a_addr_d;
         a_data_q  <= a_data_d;
         b_full_q  <= b_full_d;
         b_addr_q  <= b_addr_d;
         b_data_q  <= b_data_d;
         rr_ptr_q  <= rr_ptr_d;
         b_older_q <= b_older_d;
      end
   end

   always_comb begin
      bus.wr_addr = '0;
      bus.wr_data = '0;
      if (gnt_b) begin
         bus.wr_addr = b_addr_q;
         bus.wr_data = b_data_q;
      end else if (gnt_a) begin
         bus.wr_addr = a_addr_q;
         bus.wr_data = a_data_q;
      end
   end

   assign bus.wr_en   = gnt_a || gnt_b;
   assign bus.wr_src  = gnt_b;
   assign bus.a_ready = a_rdy;
   assign bus.b_ready = b_rdy;
   assign bus.busy    = !reset && (a_full_q || b_full_q);
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed vector table, saturation scoreboard,
// and randomized traffic against a pending-entry reference model.
module tb_regwrite_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   regwrite_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();
   regwrite_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic rst; logic av; logic [4:0] aa; logic [31:0] ad;
      logic bv; logic [4:0] ba; logic [31:0] bd;
      logic en; logic [4:0] wa; logic [31:0] wd; logic src;
      logic ar; logic br; logic bsy;
   } vec_t;

   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   typedef struct { bit v; logic [4:0] a; logic [31:0] d; int unsigned st; } pend_t;

   vec_t        tbl [34];
   ent_t        qa [$];
   ent_t        qb [$];
   pend_t       pm [2];
   bit          turn;
   int unsigned stamp;
   logic [31:0] rf_m [32];
   logic [31:0] rf_d [32];

   function automatic vec_t mk(logic rst, logic av, logic [4:0] aa, logic [31:0] ad,
                               logic bv, logic [4:0] ba, logic [31:0] bd,
                               logic en, logic [4:0] wa, logic [31:0] wd, logic src,
                               logic ar, logic br, logic bsy);
      vec_t v;
      v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
      v.en = en; v.wa = wa; v.wd = wd; v.src = src; v.ar = ar; v.br = br; v.bsy = bsy;
      return v;
   endfunction

   function automatic logic [63:0] dut_out();
      return {22'd0, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_src,
              bus.a_ready, bus.b_ready, bus.busy};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      reset = rst;
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
   endtask

   function automatic int pick();
      if (pm[0].v && pm[1].v) begin
         if (pm[0].a == pm[1].a) return (pm[0].st < pm[1].st) ? 0 : 1;
         return turn ? 1 : 0;
      end
      if (pm[0].v) return 0;
      if (pm[1].v) return 1;
      return -1;
   endfunction

   task automatic sb_write(input string nm);
      ent_t e;
      if (bus.wr_src ? (qb.size() == 0) : (qa.size() == 0)) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: unexpected write addr %0h data %0h src %0d", nm, bus.wr_addr, bus.wr_data, bus.wr_src);
      end else begin
         e = bus.wr_src ? qb.pop_front() : qa.pop_front();
         chk(nm, {bus.wr_addr, bus.wr_data}, {e.a, e.d});
      end
   endtask

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      tbl[0]  = mk(1, 1, 3, 'h11, 0, 0, 0,      0, 0, 0, 0,        0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[3]  = mk(0, 1, 3, 'h11, 0, 0, 0,      0, 0, 0, 0,        1, 1, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,         1, 3, 'h11, 0,     1, 1, 1);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[6]  = mk(0, 1, 4, 'hAA, 1, 5, 'hBB,   0, 0, 0, 0,        1, 1, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,         1, 4, 'hAA, 0,     1, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,         1, 5, 'hBB, 1,     1, 1, 1);
      tbl[9]  = mk(0, 1, 4, 'hAA, 1, 5, 'hBB,   0, 0, 0, 0,        1, 1, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,         1, 5, 'hBB, 1,     0, 1, 1);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,         1, 4, 'hAA, 0,     1, 1, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[13] = mk(0, 0, 0, 0, 1, 7, 'h1,       0, 0, 0, 0,        1, 1, 0);
      tbl[14] = mk(0, 1, 7, 'h2, 0, 0, 0,       1, 7, 'h1, 1,      1, 1, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,         1, 7, 'h2, 0,      1, 1, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[17] = mk(0, 1, 4, 'h1, 1, 5, 'h2,     0, 0, 0, 0,        1, 1, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,         1, 4, 'h1, 0,      1, 0, 1);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,         1, 5, 'h2, 1,      1, 1, 1);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[21] = mk(0, 1, 6, 'h3, 1, 6, 'h4,     0, 0, 0, 0,        1, 1, 0);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,         1, 6, 'h3, 0,      1, 0, 1);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,         1, 6, 'h4, 1,      1, 1, 1);
      tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[25] = mk(0, 1, 0, 'hFF, 0, 0, 0,      0, 0, 0, 0,        1, 1, 0);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[27] = mk(0, 1, 10, 'h10, 1, 11, 'h20, 0, 0, 0, 0,        1, 1, 0);
      tbl[28] = mk(1, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        0, 0, 0);
      tbl[29] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);
      tbl[30] = mk(0, 1, 12, 'h40, 1, 13, 'h50, 0, 0, 0, 0,        1, 1, 0);
      tbl[31] = mk(0, 0, 0, 0, 0, 0, 0,         1, 12, 'h40, 0,    1, 0, 1);
      tbl[32] = mk(0, 0, 0, 0, 0, 0, 0,         1, 13, 'h50, 1,    1, 1, 1);
      tbl[33] = mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        1, 1, 0);

      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
         @(negedge clk);
         chk($sformatf("row%0d", i), dut_out(),
             {22'd0, tbl[i].en, tbl[i].wa, tbl[i].wd, tbl[i].src, tbl[i].ar, tbl[i].br, tbl[i].bsy});
         @(posedge clk); #1;
      end

      // Saturation: pointer sits at B after row 31, so B wins the first conflict.
      for (int c = 0; c < 20; c++) begin
         drive(0, 1, 5'(1 + c % 15), 32'h1000 + 32'(c), 1, 5'(16 + c % 15), 32'h2000 + 32'(c));
         @(negedge clk);
         if (c == 0) chk("sat_ready0", {bus.a_ready, bus.b_ready, bus.wr_en}, 3'b110);
         else chk($sformatf("sat%0d", c), {bus.a_ready, bus.b_ready, bus.wr_en, bus.wr_src},
                  (c % 2 == 1) ? 4'b0111 : 4'b1010);
         if (bus.wr_en) sb_write($sformatf("sat_sb%0d", c));
         if (bus.a_ready) qa.push_back('{5'(1 + c % 15), 32'h1000 + 32'(c)});
         if (bus.b_ready) qb.push_back('{5'(16 + c % 15), 32'h2000 + 32'(c)});
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.wr_en) sb_write($sformatf("drain%0d", c));
         @(posedge clk); #1;
      end
      chk("sat_left", 64'(qa.size() + qb.size()), 0);

      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      pm[0] = '{0, 0, 0, 0};
      pm[1] = '{0, 0, 0, 0};
      turn  = 0;
      stamp = 0;
      for (int i = 0; i < 32; i++) begin
         rf_m[i] = '0;
         rf_d[i] = '0;
      end

      for (int c = 0; c < 400; c++) begin
         logic        r, av, bv, ar, br, bsy, en, both;
         logic [4:0]  aa, ba, wa;
         logic [31:0] ad, bd, wd;
         int          g;
         r  = (c < 395) && ($urandom_range(0, 39) == 0);
         av = (c < 395) && $urandom_range(0, 1) == 1;
         bv = (c < 395) && $urandom_range(0, 1) == 1;
         aa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         ba = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         ad = $urandom;
         bd = $urandom;
         drive(r, av, aa, ad, bv, ba, bd);
         @(negedge clk);
         g   = r ? -1 : pick();
         en  = (g >= 0);
         wa  = en ? pm[g].a : 5'd0;
         wd  = en ? pm[g].d : 32'd0;
         ar  = !r && (!pm[0].v || g == 0);
         br  = !r && (!pm[1].v || g == 1);
         bsy = !r && (pm[0].v || pm[1].v);
         chk($sformatf("rand%0d", c), dut_out(),
             {22'd0, en, wa, wd, (g == 1), ar, br, bsy});
         if (bus.wr_en) rf_d[bus.wr_addr] = bus.wr_data;
         @(posedge clk);
         if (r) begin
            pm[0].v = 0;
            pm[1].v = 0;
            turn = 0;
         end else begin
            both = pm[0].v && pm[1].v;
            if (g >= 0) begin
               rf_m[pm[g].a] = pm[g].d;
               if (both) turn = (g == 0);
               pm[g].v = 0;
            end
            if (av && ar && aa != 0) begin pm[0] = '{1, aa, ad, stamp}; stamp++; end
            if (bv && br && ba != 0) begin pm[1] = '{1, ba, bd, stamp}; stamp++; end
         end
         #1;
      end
      for (int i = 1; i < 32; i++) chk($sformatf("rf%0d", i), rf_d[i], rf_m[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
